// File: rtl/apb_slave_memif_if.sv
// -----------------------------------------------------------------------------
// apb_slave_memif_if
//   APB bus bundle between an APB master and apb_slave_memif.
//
//   Parameters
//     BUS_WIDTH  : APB data width (bits), STRB_WIDTH = BUS_WIDTH/8
//     ADDR_WIDTH : APB address width (bits)
//
//   Signals (direction seen from the slave)
//     psel_i, penable_i, pwrite_i  : APB control, inputs
//     pstrb_i, pwdata_i, paddr_i   : APB write strobes / data / address, inputs
//     pready_o, pslverr_o, prdata_o: APB completion, error and read data, outputs
//
//   Modports
//     slave  : used by apb_slave_memif
//     master : used by whoever drives the bus (CPU, testbench)
// -----------------------------------------------------------------------------
interface apb_slave_memif_if #(
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 32
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;

    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [STRB_WIDTH-1:0] pstrb_i;
    logic [BUS_WIDTH-1:0]  pwdata_i;
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic                  pready_o;
    logic                  pslverr_o;
    logic [BUS_WIDTH-1:0]  prdata_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
        output pready_o, pslverr_o, prdata_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
        input  pready_o, pslverr_o, prdata_o
    );
endinterface

// File: rtl/apb_slave_memif.sv
// -----------------------------------------------------------------------------
// apb_slave_memif
//   APB slave in front of the matmul register/operand memory. Each APB transfer
//   becomes one single-beat request on a simple memory port (byte enables on
//   writes, variable-latency read data). PREADY/PSLVERR/PRDATA are registered.
//   Accesses are refused with PSLVERR while the engine runs (start_bit_i).
//
//   Optional build macro: APB_SLV_READ_TIMEOUT_EN
//     defined   : a read that sees no mem_rvalid_i within MEM_TIMEOUT WAIT_RD
//                 cycles completes with PSLVERR and zero data
//     undefined : reads wait for mem_rvalid_i indefinitely, no counter exists
//
//   Ports
//     clk_i, rst_ni      : clock (rising edge), asynchronous active-low reset
//     apb                : APB slave modport (psel/penable/pwrite/pstrb/pwdata/
//                          paddr in, pready/pslverr/prdata out)
//     start_bit_i        : engine running, any access is an error
//     busy_o             : transfer in progress
//     mem_req_o          : one-cycle request pulse
//     mem_we_o           : request is a write
//     mem_addr_o         : request address
//     mem_wdata_o        : write data
//     mem_be_o           : byte enables (zero on reads)
//     mem_rdata_i        : read data
//     mem_rvalid_i       : read data valid
// -----------------------------------------------------------------------------
module apb_slave_memif #(
    parameter int         DATA_WIDTH   = 32,
    parameter int         BUS_WIDTH    = 64,
    parameter int         ADDR_WIDTH   = 32,
    parameter logic [4:0] FLAGS_OFFSET = 5'h0C,
    parameter logic [4:0] SP_OFFSET    = 5'h10,
    parameter int         MEM_TIMEOUT  = 15,
    localparam int        STRB_WIDTH   = BUS_WIDTH / 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    apb_slave_memif_if.slave       apb,
    input  logic                   start_bit_i,
    output logic                   busy_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [BUS_WIDTH-1:0]   mem_wdata_o,
    output logic [STRB_WIDTH-1:0]  mem_be_o,
    input  logic [BUS_WIDTH-1:0]   mem_rdata_i,
    input  logic                   mem_rvalid_i
);

    if ((BUS_WIDTH % DATA_WIDTH) != 0) begin : g_bad_bus_width
        $error("BUS_WIDTH must be a multiple of DATA_WIDTH");
    end
    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be at least 1");
    end

    // Low address bits that must be zero for a bus-width aligned access.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        WAIT_RD,
        RESP
    } state_e;

    state_e                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [BUS_WIDTH-1:0]   prdata_q, prdata_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [BUS_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0]  mem_be_q, mem_be_d;

    // Transfer captured in the setup phase.
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   write_q, write_d;
    logic [STRB_WIDTH-1:0]  strb_q, strb_d;
    logic [BUS_WIDTH-1:0]   wdata_q, wdata_d;

    logic                   abort;

`ifdef APB_SLV_READ_TIMEOUT_EN
    localparam int TO_W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
`endif

    // Access rules: flags and scratchpad are read-only, reads carry no strobes,
    // nothing is allowed while the engine runs, and accesses must be aligned.
    function automatic logic access_err(
        input logic                  wr,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [STRB_WIDTH-1:0] strb,
        input logic                  start
    );
        logic [4:0] reg_off;
        reg_off = addr[4:0];
        return (wr && (reg_off == FLAGS_OFFSET)) ||
               (wr && (reg_off >= SP_OFFSET))    ||
               (!wr && (strb != '0))             ||
               start                             ||
               ((addr & ALIGN_MASK) != '0);
    endfunction

    // Dropping PSEL outside IDLE abandons the transfer; an already issued
    // memory request is left to complete and its read data is ignored.
    assign abort = (state_q != IDLE) && !apb.psel_i;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        pready_d    = 1'b0;
        pslverr_d   = pslverr_q;
        prdata_d    = prdata_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_be_d    = '0;
        addr_d      = addr_q;
        write_d     = write_q;
        strb_d      = strb_q;
        wdata_d     = wdata_q;
`ifdef APB_SLV_READ_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif

        if (abort) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    busy_d    = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                    if (apb.psel_i && !apb.penable_i) begin
                        addr_d  = apb.paddr_i;
                        write_d = apb.pwrite_i;
                        strb_d  = apb.pstrb_i;
                        wdata_d = apb.pwdata_i;
                        busy_d  = 1'b1;
                        state_d = CHECK;
                    end
                end

                CHECK: begin
                    if (access_err(write_q, addr_q, strb_q, start_bit_i)) begin
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                        pready_d  = apb.penable_i;
                        state_d   = RESP;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = write_q;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = wdata_q;
                        mem_be_d    = write_q ? strb_q : '0;
                        state_d     = REQ;
                    end
                end

                REQ: begin
`ifdef APB_SLV_READ_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    if (write_q) begin
                        pready_d = apb.penable_i;
                        state_d  = RESP;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end

                WAIT_RD: begin
                    if (mem_rvalid_i) begin
                        prdata_d = mem_rdata_i;
                        pready_d = apb.penable_i;
                        state_d  = RESP;
                    end
`ifdef APB_SLV_READ_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        pslverr_d = 1'b1;
                        prdata_d  = '0;
                        pready_d  = apb.penable_i;
                        state_d   = RESP;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
`else
                    // Without the timeout the read waits for the memory forever.
`endif
                end

                RESP: begin
                    // PREADY is already up when PENABLE was high on entry;
                    // otherwise it is raised once PENABLE arrives.
                    if (pready_q) begin
                        busy_d    = 1'b0;
                        pslverr_d = 1'b0;
                        prdata_d  = '0;
                        state_d   = IDLE;
                    end else if (apb.penable_i) begin
                        pready_d = 1'b1;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
`ifdef APB_SLV_READ_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            prdata_q    <= prdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
`ifdef APB_SLV_READ_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    // Captured transfer fields are only consumed after a setup phase loads
    // them, so they need no reset.
    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        write_q <= write_d;
        strb_q  <= strb_d;
        wdata_q <= wdata_d;
    end

    assign apb.pready_o  = pready_q;
    assign apb.pslverr_o = pslverr_q;
    assign apb.prdata_o  = prdata_q;
    assign busy_o        = busy_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign mem_be_o      = mem_be_q;

endmodule

// File: tb/tb_apb_slave_memif.sv
module tb_apb_slave_memif;
    localparam int BW = 64;
    localparam int AW = 32;
    localparam int SW = 8;
    localparam int MEM_TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    apb_slave_memif_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) apb_bus ();

    logic          start_bit;
    logic          busy;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;
    logic [SW-1:0] mem_be;
    logic [BW-1:0] mem_rdata;
    logic          mem_rvalid;

    apb_slave_memif #(
        .DATA_WIDTH  (32),
        .BUS_WIDTH   (BW),
        .ADDR_WIDTH  (AW),
        .FLAGS_OFFSET(5'h0C),
        .SP_OFFSET   (5'h10),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .apb         (apb_bus.slave),
        .start_bit_i (start_bit),
        .busy_o      (busy),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_rdata_i (mem_rdata),
        .mem_rvalid_i(mem_rvalid)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [191:0] act, logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- scoreboard queues ----------------
    typedef struct {
        logic          err;
        logic [BW-1:0] rdata;
    } resp_t;
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [SW-1:0] be;
    } memreq_t;
    resp_t   resp_q[$];
    memreq_t mreq_q[$];

    // Initial memory contents, shared knowledge of the environment.
    function automatic logic [BW-1:0] init_word(logic [AW-1:0] a);
        return 64'hA5A5_5A5A_0000_0000 | BW'(a);
    endfunction

    // ---------------- reference model: word array ----------------
    logic [BW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [BW-1:0] ref_read(logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic void ref_write(logic [AW-1:0] a, logic [SW-1:0] strb, logic [BW-1:0] d);
        logic [BW-1:0] w;
        w = ref_read(a);
        for (int b = 0; b < SW; b++)
            if (strb[b]) w[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[a] = w;
    endfunction

    // ---------------- memory responder ----------------
    logic [BW-1:0] dev_mem [logic [AW-1:0]];
    int            rd_cnt = 0;
    logic [AW-1:0] rd_addr = '0;
    int            next_lat = 1;
    bit            no_resp = 1'b0;

    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = dev_mem.exists(rd_addr) ? dev_mem[rd_addr] : init_word(rd_addr);
                end
            end
        end
    end

    // Memory-side monitor: every request must match the next expected one.
    initial begin
        memreq_t e;
        logic [BW-1:0] w;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req === 1'b1) begin
                if (mreq_q.size() == 0) begin
                    check("mem_req_unexpected", 192'(mem_req), 192'(0));
                end else begin
                    e = mreq_q.pop_front();
                    check("mem_req", {87'(0), mem_we, mem_addr, mem_wdata, mem_be},
                                     {87'(0), e.we, e.addr, e.wdata, e.be});
                end
                if (mem_we) begin
                    w = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_word(mem_addr);
                    for (int b = 0; b < SW; b++)
                        if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
                    dev_mem[mem_addr] = w;
                end else if (!no_resp) begin
                    rd_addr = mem_addr;
                    rd_cnt  = next_lat;
                end
            end
        end
    end

    // APB response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && apb_bus.pready_o === 1'b1) begin
                if (resp_q.size() == 0) begin
                    check("pready_unexpected", 192'(apb_bus.pready_o), 192'(0));
                end else begin
                    e = resp_q.pop_front();
                    check("apb_resp", {127'(0), apb_bus.pslverr_o, apb_bus.prdata_o},
                                      {127'(0), e.err, e.rdata});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // One APB transfer. lat: memory read latency; pen_k: cycle in which
    // PENABLE rises (1 = normal APB); nr: memory never answers the read.
    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [SW-1:0] strb,
                        input logic [BW-1:0] wd, input bit st, input int lat,
                        input int pen_k, input bit nr);
        bit            err;
        logic [4:0]    a5;
        logic [BW-1:0] rd;
        int            e, exp_lat, n;
        bit            busy_ok;
        a5  = addr[4:0];
        err = (wr && a5 == 5'h0C) || (wr && a5 >= 5'h10) || (!wr && strb != 0) ||
              st || (addr % SW != 0);
        rd  = (!wr && !err) ? ref_read(addr) : '0;
        e   = err ? 2 : (wr ? 3 : 3 + lat);
        if (!wr && !err && nr) begin
            rd  = '0;
            e   = 3 + MEM_TIMEOUT;
            err = 1'b1;
            mreq_q.push_back('{1'b0, addr, wd, '0});
        end else if (!err) begin
            mreq_q.push_back('{wr, addr, wd, wr ? strb : '0});
        end
        exp_lat = (pen_k <= e - 1) ? e : pen_k + 1;
        resp_q.push_back('{err, rd});
        no_resp  = nr;
        next_lat = lat;

        apb_bus.psel_i    = 1'b1;
        apb_bus.penable_i = 1'b0;
        apb_bus.pwrite_i  = wr;
        apb_bus.paddr_i   = addr;
        apb_bus.pstrb_i   = strb;
        apb_bus.pwdata_i  = wd;
        start_bit         = st;
        n       = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == pen_k) apb_bus.penable_i = 1'b1;
            if (c == 2) start_bit = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (apb_bus.pready_o === 1'b1) begin
                n = c;
                break;
            end
        end
        if (n == 0) begin
            check("pready_seen", 192'(apb_bus.pready_o), 192'(1));
        end else begin
            check("latency", 192'(n), 192'(exp_lat));
            check("busy_during", 192'(busy_ok), 192'(1));
        end
        @(posedge clk);
        #1;
        apb_bus.psel_i    = 1'b0;
        apb_bus.penable_i = 1'b0;
        start_bit         = 1'b0;
        @(negedge clk);
        check("idle_after", {125'(0), busy, apb_bus.pready_o, apb_bus.pslverr_o, apb_bus.prdata_o}, 192'(0));
        if (wr && !err) ref_write(addr, strb, wd);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {147'(0), apb_bus.pready_o, apb_bus.pslverr_o, busy, mem_req,
                                 mem_we, mem_be, mem_addr}, 192'(0));
        check({name, "_data"}, {64'(0), apb_bus.prdata_o, mem_wdata}, 192'(0));
    endtask

    // Start a read at addr with memory latency lat and stop after cycle 3 (WAIT_RD).
    task automatic start_read(input logic [AW-1:0] addr, input int lat);
        mreq_q.push_back('{1'b0, addr, '0, '0});
        next_lat = lat;
        no_resp  = 1'b0;
        apb_bus.psel_i    = 1'b1;
        apb_bus.penable_i = 1'b0;
        apb_bus.pwrite_i  = 1'b0;
        apb_bus.paddr_i   = addr;
        apb_bus.pstrb_i   = '0;
        apb_bus.pwdata_i  = '0;
        @(posedge clk); #1; apb_bus.penable_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit            wr, st, saw;
        logic [AW-1:0] a;
        logic [SW-1:0] s;
        int            pk;

        apb_bus.psel_i    = 1'b0;
        apb_bus.penable_i = 1'b0;
        apb_bus.pwrite_i  = 1'b0;
        apb_bus.paddr_i   = '0;
        apb_bus.pstrb_i   = '0;
        apb_bus.pwdata_i  = '0;
        start_bit         = 1'b0;
        ref_mem[32'h8]    = 64'hDEADBEEF_CAFEF00D;
        dev_mem[32'h8]    = 64'hDEADBEEF_CAFEF00D;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        xfer(1, 32'h00, 8'hFF, 64'h1122334455667788, 0, 1, 1, 0);
        xfer(0, 32'h08, 8'h00, '0, 0, 2, 1, 0);
        xfer(1, 32'h0C, 8'hFF, 64'h0123456789ABCDEF, 0, 1, 1, 0);
        xfer(1, 32'h10, 8'hFF, 64'h0123456789ABCDEF, 0, 1, 1, 0);
        xfer(0, 32'h00, 8'h01, '0, 0, 1, 1, 0);
        xfer(0, 32'h08, 8'h00, '0, 1, 1, 1, 0);
        xfer(1, 32'h00, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 0);
        xfer(1, 32'h00, 8'hF0, 64'hAABBCCDD_EEFF0011, 0, 1, 1, 0);
        xfer(0, 32'h00, 8'h00, '0, 0, 3, 1, 0);
        xfer(1, 32'h08, 8'h00, 64'h5555_5555_5555_5555, 0, 1, 1, 0);
        xfer(0, 32'h08, 8'h00, '0, 0, 1, 1, 0);
        xfer(1, 32'h20, 8'h0F, 64'h1234_5678_9ABC_DEF0, 0, 1, 5, 0);
        xfer(0, 32'h20, 8'h00, '0, 0, 1, 4, 0);

        // Abort in WAIT_RD; late read data must be ignored.
        start_read(32'h08, 4);
        #1;
        apb_bus.psel_i    = 1'b0;
        apb_bus.penable_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy", {190'(0), busy, apb_bus.pready_o}, 192'(0));
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (apb_bus.pready_o === 1'b1) saw = 1'b1;
        end
        check("abort_no_pready", 192'(saw), 192'(0));
        xfer(0, 32'h00, 8'h00, '0, 0, 2, 1, 0);

        // Reset mid-read: outputs clear at once.
        start_read(32'h18, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        apb_bus.psel_i    = 1'b0;
        apb_bus.penable_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_idle", {190'(0), busy, apb_bus.pready_o}, 192'(0));
        xfer(0, 32'h18, 8'h00, '0, 0, 1, 1, 0);
        xfer(1, 32'h28, 8'hFF, 64'h0F0F_0F0F_F0F0_F0F0, 0, 1, 1, 0);

`ifdef APB_SLV_READ_TIMEOUT_EN
        xfer(0, 32'h18, 8'h00, '0, 0, 1, 1, 1);
        repeat (4) @(negedge clk);
`endif

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 7) * 8);
            if ($urandom_range(0, 7) == 0) a = a + AW'($urandom_range(1, 7));
            if (wr) s = SW'($urandom_range(0, 255));
            else    s = ($urandom_range(0, 5) == 0) ? SW'($urandom_range(1, 255)) : '0;
            st = ($urandom_range(0, 9) == 0);
            pk = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 1;
            xfer(wr, a, s, {$urandom, $urandom}, st, $urandom_range(1, 5), pk, 0);
        end

        repeat (5) @(negedge clk);
        check("resp_q_empty", 192'(resp_q.size()), 192'(0));
        check("mreq_q_empty", 192'(mreq_q.size()), 192'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
